// File: rtl/decode_h3_pipe.sv
// H3 SECDED decoder: 32-bit codeword {data[25:0], p[5:0]} in, corrected 26-bit data out.
// Two-stage valid/ready pipeline with saturating single/double error counters.
module decode_h3_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] cw_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [25:0]           data_out,
  output logic [1:0]            err_status,
  output logic [4:0]            err_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  single_cnt,
  output logic [CNT_WIDTH-1:0]  double_cnt
);

  localparam int DW = 26;

  // Hamming position of data bit idx: the idx-th non-power-of-two in 3..31.
  function automatic logic [4:0] data_pos(input int idx);
    int n;
    data_pos = '0;
    n = 0;
    for (int p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) data_pos = 5'(p);
        n++;
      end
    end
  endfunction

  function automatic logic [DW-1:0] cover_mask(input int k);
    logic [4:0] pos;
    cover_mask = '0;
    for (int i = 0; i < DW; i++) begin
      pos = data_pos(i);
      cover_mask[i] = pos[k];
    end
  endfunction

  logic [DW-1:0] in_data;
  logic [4:0]    in_par;
  logic [4:0]    syn;
  logic          ov;

  assign in_data = cw_in[31:6];
  assign in_par  = cw_in[4:0];
  assign ov      = ^cw_in;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_syn
      localparam logic [DW-1:0] MASK = cover_mask(gi);
      assign syn[gi] = in_par[gi] ^ (^(in_data & MASK));
    end
  endgenerate

  logic                 s1_valid_reg;
  logic [DW-1:0]        s1_data_reg;
  logic [4:0]           s1_syn_reg;
  logic                 s1_ov_reg;
  logic                 s2_valid_reg;
  logic [DW-1:0]        data_out_reg;
  logic [1:0]           status_reg;
  logic [4:0]           pos_reg;
  logic [CNT_WIDTH-1:0] single_cnt_reg;
  logic [CNT_WIDTH-1:0] double_cnt_reg;

  logic s1_ready;
  logic s2_ready;
  logic out_fire;

  assign s2_ready = !s2_valid_reg || out_ready;
  assign s1_ready = !s1_valid_reg || s2_ready;
  assign out_fire = s2_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_syn_reg   <= '0;
      s1_ov_reg    <= 1'b0;
    end else if (s1_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg <= in_data;
        s1_syn_reg  <= syn;
        s1_ov_reg   <= ov;
      end
    end
  end

  // A data bit is flipped only when overall parity fails and the syndrome names it;
  // parity-bit positions never match a data position, so they leave data intact.
  logic [DW-1:0] flip;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_fix
      localparam logic [4:0] POS = data_pos(gi);
      assign flip[gi] = s1_ov_reg && (s1_syn_reg == POS);
    end
  endgenerate

  logic [DW-1:0] fix_data;
  logic [1:0]    fix_status;
  logic [4:0]    fix_pos;

  always_comb begin
    fix_data   = s1_data_reg ^ flip;
    fix_status = 2'b00;
    fix_pos    = '0;
    if (s1_ov_reg) begin
      fix_status = 2'b01;
      fix_pos    = s1_syn_reg;
    end else if (s1_syn_reg != '0) begin
      fix_status = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
      data_out_reg <= '0;
      status_reg   <= 2'b00;
      pos_reg      <= '0;
    end else if (s2_ready) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        data_out_reg <= fix_data;
        status_reg   <= fix_status;
        pos_reg      <= fix_pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      single_cnt_reg <= '0;
      double_cnt_reg <= '0;
    end else if (cnt_clr) begin
      single_cnt_reg <= '0;
      double_cnt_reg <= '0;
    end else if (out_fire) begin
      if (status_reg == 2'b01 && single_cnt_reg != '1)
        single_cnt_reg <= single_cnt_reg + CNT_WIDTH'(1);
      if (status_reg == 2'b10 && double_cnt_reg != '1)
        double_cnt_reg <= double_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign in_ready   = s1_ready;
  assign out_valid  = s2_valid_reg;
  assign data_out   = data_out_reg;
  assign err_status = status_reg;
  assign err_pos    = pos_reg;
  assign single_cnt = single_cnt_reg;
  assign double_cnt = double_cnt_reg;

endmodule

// File: tb/tb_decode_h3_pipe.sv
// Bench for decode_h3_pipe: words are built by encoding data and injecting 0/1/2 known bit
// flips, so expected results follow from the injected error rather than from a decoder.
module tb_decode_h3_pipe;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cw_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [25:0]   data_out;
  logic [1:0]    err_status;
  logic [4:0]    err_pos;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] single_cnt;
  logic [CW-1:0] double_cnt;

  always #5 clk = ~clk;

  decode_h3_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cw_in(cw_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .err_status(err_status), .err_pos(err_pos),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  typedef struct packed {
    logic [31:0] cw;
    logic [25:0] d;
    logic [1:0]  st;
    logic [4:0]  pos;
  } item_t;

  int dpos[26] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20,
                   21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31};

  item_t         pend[$];
  item_t         fly[$];
  int            fly_t[$];
  int            checks = 0;
  int            errors = 0;
  int            edges = 0;
  int            xfers = 0;
  logic [CW-1:0] m_single = '0;
  logic [CW-1:0] m_double = '0;
  logic          saw_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 26; i++)
      for (int k = 0; k < 5; k++)
        if (((dpos[i] >> k) & 1) != 0) p[k] = p[k] ^ d[i];
    p[5] = (^d) ^ (^p[4:0]);
    return {d, p};
  endfunction

  // Hamming position of codeword bit b (p5 has none and reports 0).
  function automatic int bit_pos(input int b);
    if (b < 5) return 1 << b;
    if (b == 5) return 0;
    return dpos[b - 6];
  endfunction

  function automatic item_t make_item(input logic [25:0] d, input int nflip);
    item_t       it;
    int          b1, b2;
    logic [31:0] c;
    c  = encode(d);
    b1 = int'($urandom_range(0, 31));
    b2 = b1;
    while (b2 == b1) b2 = int'($urandom_range(0, 31));
    it.d   = d;
    it.st  = 2'd0;
    it.pos = 5'd0;
    if (nflip == 1) begin
      c[b1]  = ~c[b1];
      it.st  = 2'd1;
      it.pos = 5'(bit_pos(b1));
    end else if (nflip == 2) begin
      c[b1] = ~c[b1];
      c[b2] = ~c[b2];
      it.st = 2'd2;
      it.d  = c[31:6];
    end
    it.cw = c;
    return it;
  endfunction

  task automatic run_cycle(input bit iv, input bit ordy, input bit clr);
    logic exp_ov, exp_rdy;
    @(posedge clk);
    edges++;
    #1;
    in_valid  = iv && (pend.size() > 0);
    cw_in     = (pend.size() > 0) ? pend[0].cw : 32'($urandom());
    out_ready = ordy;
    cnt_clr   = clr;
    @(negedge clk);
    exp_rdy = (fly.size() < 2) || ordy;
    exp_ov  = (fly.size() > 0) && (fly_t[0] < edges);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (!in_ready) saw_stall = 1'b1;
    if (exp_ov && out_valid) begin
      check("data_out", 32'(data_out), 32'(fly[0].d));
      check("err_status", 32'(err_status), 32'(fly[0].st));
      check("err_pos", 32'(err_pos), 32'(fly[0].pos));
    end
    check("single_cnt", 32'(single_cnt), 32'(m_single));
    check("double_cnt", 32'(double_cnt), 32'(m_double));
    if (clr) begin
      m_single = '0;
      m_double = '0;
    end else if (exp_ov && ordy) begin
      if (fly[0].st == 2'd1 && m_single != CMAX) m_single = m_single + CW'(1);
      if (fly[0].st == 2'd2 && m_double != CMAX) m_double = m_double + CW'(1);
    end
    if (exp_ov && ordy) begin
      xfers++;
      $display("xfer %0d cw=%h data=%h st=%0d pos=%0d", xfers, fly[0].cw, fly[0].d,
               fly[0].st, fly[0].pos);
      void'(fly.pop_front());
      void'(fly_t.pop_front());
    end
    if (in_valid && exp_rdy) begin
      fly.push_back(pend[0]);
      fly_t.push_back(edges + 1);
      void'(pend.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b0;
    #10;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_err_status", 32'(err_status), 32'd0);
    check("rst_err_pos", 32'(err_pos), 32'd0);
    check("rst_single", 32'(single_cnt), 32'd0);
    check("rst_double", 32'(double_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed words: clean, data-bit error, p1 error, p5 error, double error.
    pend.push_back('{32'h00000063, 26'h1, 2'd0, 5'd0});
    pend.push_back('{32'h00000023, 26'h1, 2'd1, 5'd3});
    pend.push_back('{32'h00000061, 26'h1, 2'd1, 5'd2});
    pend.push_back('{32'h00000043, 26'h1, 2'd1, 5'd0});
    pend.push_back('{32'h00000003, 26'h0, 2'd2, 5'd0});
    for (int c = 0; c < 8; c++) run_cycle(1'b1, 1'b1, 1'b0);
    check("dir_single_cnt", 32'(single_cnt), 32'd3);
    check("dir_double_cnt", 32'(double_cnt), 32'd1);

    // Eight back-to-back words with a four-cycle downstream stall.
    for (int i = 0; i < 8; i++) pend.push_back(make_item(26'($urandom()), int'($urandom_range(0, 2))));
    saw_stall = 1'b0;
    for (int c = 0; c < 12; c++) run_cycle(1'b1, !(c >= 3 && c <= 6), 1'b0);
    for (int c = 0; c < 6; c++) run_cycle(1'b1, 1'b1, 1'b0);
    check("stall_seen", 32'(saw_stall), 32'd1);

    // Saturate single_cnt, then clear it on the cycle of another increment.
    run_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) pend.push_back(make_item(26'($urandom()), 1));
    for (int c = 0; c < 22; c++) run_cycle(1'b1, 1'b1, 1'b0);
    check("sat_single_cnt", 32'(single_cnt), 32'(CMAX));
    pend.push_back(make_item(26'($urandom()), 1));
    run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0);
    check("clr_wins_single", 32'(single_cnt), 32'd0);

    // Random traffic with random backpressure and occasional clears.
    for (int c = 0; c < 500; c++) begin
      if (pend.size() < 2) pend.push_back(make_item(26'($urandom()), int'($urandom_range(0, 2))));
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
    end

    // Reset with both stages full and counters non-zero.
    pend.delete();
    pend.push_back(make_item(26'($urandom()), 1));
    pend.push_back(make_item(26'($urandom()), 2));
    for (int c = 0; c < 3; c++) run_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pend.push_back(make_item(26'($urandom()), 0));
    for (int c = 0; c < 3; c++) run_cycle(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_single", 32'(single_cnt), 32'd0);
    check("arst_double", 32'(double_cnt), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    fly.delete();
    fly_t.delete();
    pend.delete();
    m_single = '0;
    m_double = '0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (pend.size() < 2) pend.push_back(make_item(26'($urandom()), int'($urandom_range(0, 2))));
      run_cycle(1'b1, $urandom_range(0, 3) != 0, 1'b0);
    end
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_h3_pipe.md
Name: decode_h3_pipe

Overview:
- Downstream consumer of the H3 32-bit Hamming SECDED encoder.
- Accepts 32-bit codewords through a valid/ready handshake and recomputes the syndrome and overall parity. It corrects any single-bit error, flags double-bit errors and returns the 26 data bits.
- Two-stage pipeline with saturating error-statistics counters that register-file logic can read.

Parameters:
- DATA_WIDTH, 32, codeword width; fixed at 32 for H3 mode, other values unsupported.
- CNT_WIDTH, 16, width of each error-statistics counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cw_in  input  DATA_WIDTH  codeword laid out as {data[25:0], p[5:0]}.
- in_valid  input  1  cw_in is valid.
- in_ready  output  1  block can accept cw_in this cycle.
- data_out  output  26  corrected data.
- err_status  output  2  00 no error, 01 single error corrected, 10 double error (uncorrectable), 11 never driven.
- err_pos  output  5  Hamming position (1..31) of the corrected bit; 0 when there is no error, the error is in p5, or the error is a double.
- out_valid  output  1  outputs are valid.
- out_ready  input  1  downstream accepts the outputs.
- cnt_clr  input  1  synchronous clear of both counters.
- single_cnt  output  CNT_WIDTH  number of corrected words delivered.
- double_cnt  output  CNT_WIDTH  number of double-error words delivered.

Behaviour:
- Hamming position map:
  - Data bit d[i] occupies the i-th non-power-of-two position in 3..31 (d0=3, d1=5, d2=6, d3=7, d4=9 ... d25=31).
  - p[k] (k=0..4) occupies position 2^k.
  - p5 is the overall parity over d[25:0] and p[4:0].
- Syndrome and overall parity:
  - s[4:0] = received p[4:0] XOR the p[4:0] recomputed from the received data.
  - ov = XOR of all 32 received bits.
- Classification:
  - s=0, ov=0: no error; data_out = received data; status 00; err_pos 0.
  - ov=1, s=0: error in p5; data unchanged; status 01; err_pos 0.
  - ov=1, s a power of two: error in a parity bit; data unchanged; status 01; err_pos=s.
  - ov=1, s any other value: invert the data bit at position s; status 01; err_pos=s.
  - s!=0, ov=0: double error; data_out = uncorrected received data; status 10; err_pos 0.
- Pipeline:
  - Stage 1 registers cw_in together with s and ov.
  - Stage 2 registers data_out, err_status and err_pos.
  - Latency is 2 cycles from input handshake to out_valid.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready, i.e. stage 1 can advance or is empty.
  - Each stage advances when the next stage is empty or is draining this cycle.
  - Full throughput: one word per cycle when out_ready=1.
  - While out_valid=1 && out_ready=0, all output ports hold stable.
  - With both stages full and out_ready=0, in_ready=0 and no data is lost.
- Counters:
  - single_cnt increments on each output transfer with status 01; double_cnt increments on each output transfer with status 10.
  - Both saturate at all-ones.
  - If cnt_clr coincides with an increment, clear wins and the counter reads 0 the next cycle.
- Reset:
  - Asynchronously clears all stage valids, data_out, err_status, err_pos and both counters to 0; out_valid=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - A reset mid-stream discards any in-flight words.

Test Plan:
- Clean word: cw_in=32'h00000063 (d=1) -> 2 cycles later data_out=26'h1, status 00, err_pos 0, counters unchanged.
- Single data error: cw_in=32'h00000023 (d0 flipped) -> data_out=26'h1, status 01, err_pos 3; single_cnt goes 0->1.
- Parity-bit errors: cw_in=32'h00000061 (p1 flipped) -> data_out=1, status 01, err_pos 2. cw_in=32'h00000043 (p5 flipped) -> status 01, err_pos 0.
- Double error: cw_in=32'h00000003 -> s=3, ov=0; status 10, data_out=0, err_pos 0; double_cnt increments.
- Backpressure and throughput:
  - 8 back-to-back words with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full; outputs hold stable.
  - All 8 words emerge in order with no loss or duplication.
  - Once out_ready=1, one word per cycle is delivered.
- Counter edges and reset:
  - Force single_cnt to 16'hFFFF, then deliver another single error -> stays 16'hFFFF.
  - Assert cnt_clr on the same cycle as an increment -> counter reads 0.
  - Assert rst with both stages full -> out_valid=0 and counters 0 immediately, with no clk edge needed.
